mio_input_ctrl: RTL and testbench

//  Memory-mapped input responder for the MIO data bus: it carries board inputs into the CPU,
//  the reverse of the seg7 output path. Synchronises and debounces the 16 switches and 5 buttons.

---
 rtl/mio_input_ctrl_if.sv | 18 +
 rtl/mio_input_ctrl.sv | 109 ++++++++++
 tb/tb_mio_input_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_input_ctrl_if.sv
// MIO bus port bundle for the input responder: CPU-side select/write/address/data
// plus the read-data and interrupt lines returned by the responder.
interface mio_input_ctrl_if;
    // Bus transfer: a write happens on any clock edge that sees sel=1 and wr=1.
    // There is no stall: the responder accepts every write and read data is
    // valid combinationally whenever sel=1.
    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, output wr, output addr, output wdata,
                    input  rdata, input irq);
    modport slave  (input  sel, input  wr, input  addr, input  wdata,
                    output rdata, output irq);
endinterface

// File: rtl/mio_input_ctrl.sv
// Board input responder: synchronises and debounces switches/buttons, latches
// rising edges as W1C sticky flags and raises a masked level interrupt.
module mio_input_ctrl #(
    parameter int N_SW       = 16,
    parameter int N_BTN      = 5,
    parameter int DB_TICK    = 100000,
    parameter int DB_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    mio_input_ctrl_if.slave  bus
);
    localparam int N  = N_SW + N_BTN;
    localparam int CW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(DB_TICK - 1);
    localparam logic [2:0]    CNT_MAX  = 3'(DB_SAMPLES - 1);

    logic [N-1:0]      sync1_q, sync2_q;
    logic [CW-1:0]     presc_q, presc_d;
    logic              tick;
    logic [N-1:0][2:0] cnt_q, cnt_d;
    logic [N-1:0]      stable_q, stable_d;
    logic [N-1:0]      stable_prev_q;
    logic [N-1:0]      rise;
    logic [N-1:0]      edge_flags_q, edge_flags_d;
    logic [N-1:0]      irq_en_q, irq_en_d;
    logic              irq_q;
    logic              wr_en;
    logic              unused_wdata;

    assign tick    = (presc_q == TICK_MAX);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign rise    = stable_q & ~stable_prev_q;
    assign wr_en   = bus.sel & bus.wr;
    assign unused_wdata = ^bus.wdata[31:N];

    // Per-bit debounce: a new level must differ from stable on DB_SAMPLES
    // consecutive ticks; any agreeing tick restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = 3'd0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = 3'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // A rise in the same cycle as a W1C write keeps the flag set.
    always_comb begin
        edge_flags_d = edge_flags_q | rise;
        irq_en_d     = irq_en_q;
        if (wr_en) begin
            case (bus.addr)
                2'd2:    edge_flags_d = (edge_flags_q & ~bus.wdata[N-1:0]) | rise;
                2'd3:    irq_en_d     = bus.wdata[N-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            presc_q       <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            edge_flags_q  <= '0;
            irq_en_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            sync1_q       <= {btn_i, sw_i};
            sync2_q       <= sync1_q;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            edge_flags_q  <= edge_flags_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= |(edge_flags_q & irq_en_q);
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.sel) begin
            case (bus.addr)
                2'd0: bus.rdata = {{(32-N_SW){1'b0}}, stable_q[N_SW-1:0]};
                2'd1: bus.rdata = {{(32-N_BTN){1'b0}}, stable_q[N-1:N_SW]};
                2'd2: bus.rdata = {{(32-N){1'b0}}, edge_flags_q};
                2'd3: bus.rdata = {{(32-N){1'b0}}, irq_en_q};
                default: bus.rdata = 32'h0;
            endcase
        end
    end

    assign bus.irq = irq_q;
endmodule

// File: tb/tb_mio_input_ctrl.sv
// Scenario bench for mio_input_ctrl with a 4-cycle tick and 3-sample debounce.
module tb_mio_input_ctrl;
    logic        clk;
    logic        rstn;
    logic [15:0] sw_i;
    logic [4:0]  btn_i;
    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    mio_input_ctrl_if bus();

    mio_input_ctrl #(.N_SW(16), .N_BTN(5), .DB_TICK(4), .DB_SAMPLES(3)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .sw_i  (sw_i),
        .btn_i (btn_i),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.sel = 1'b1;
        bus.wr  = 1'b0;
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.sel   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cyc();
        bus.wr = 1'b0;
    endtask

    // Polls a register each cycle until (value & mask) == val; cycles counts clock edges waited.
    task automatic wait_rd(input logic [1:0] a, input logic [31:0] mask, input logic [31:0] val,
                           input int budget, output int cycles, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        cycles = 0;
        while (cycles <= budget) begin
            bus_read(a, d);
            if ((d & mask) == val) begin
                ok = 1'b1;
                break;
            end
            cyc();
            cycles++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] got, exp;
        int cycles;
        bit ok;
        rstn = 1'b0;
        sw_i = 16'hFFFF;
        btn_i = 5'h0;
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
        repeat (3) cyc();
        exp_q.push_back(32'h0);
        bus_read(2'd0, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_sw_state got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL reset_irq got=%b exp=%h", bus.irq, exp); end
        rstn = 1'b1;
        // sync lands at edge 2, ticks at edges 4/8/12 -> accepted at edge 12
        exp_q.push_back(32'd12);
        wait_rd(2'd0, 32'hFFFF, 32'hFFFF, 30, cycles, ok);
        exp = exp_q.pop_front(); total++;
        if (!ok || cycles !== int'(exp)) begin
            bad++; $display("FAIL reset_sw_latency got=%0d ok=%0d exp=%0d", cycles, ok, exp);
        end
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_edge_before got=%h exp=%h", got, exp); end
        cyc();
        exp_q.push_back(32'h0000FFFF);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_edge_set got=%h exp=%h", got, exp); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_edge_clear got=%h exp=%h", got, exp); end
    endtask

    task automatic test_glitch();
        logic [31:0] got, exp;
        btn_i[0] = 1'b1;
        repeat (8) cyc();
        btn_i[0] = 1'b0;
        repeat (30) cyc();
        exp_q.push_back(32'h0);
        bus_read(2'd1, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL glitch_btn_state got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if ((got & 32'h10000) !== exp) begin bad++; $display("FAIL glitch_edge16 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_press();
        logic [31:0] got, exp;
        int cycles;
        bit ok;
        bus_write(2'd3, 32'h10000);
        btn_i[0] = 1'b1;
        exp_q.push_back(32'h1);
        wait_rd(2'd1, 32'h1F, 32'h1, 40, cycles, ok);
        bus_read(2'd1, got);
        exp = exp_q.pop_front(); total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL press_btn_state got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL press_edge_early got=%h exp=%h", got, exp); end
        cyc();
        exp_q.push_back(32'h10000);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL press_edge got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL press_irq_early got=%b exp=%h", bus.irq, exp); end
        cyc();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL press_irq got=%b exp=%h", bus.irq, exp); end
    endtask

    task automatic test_w1c();
        logic [31:0] got, exp;
        int cycles;
        bit ok;
        bus_write(2'd2, 32'h10000);
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL w1c_edge got=%h exp=%h", got, exp); end
        cyc();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL w1c_irq got=%b exp=%h", bus.irq, exp); end
        // falling edge of sw[3] must not latch
        sw_i[3] = 1'b0;
        wait_rd(2'd0, 32'h8, 32'h0, 40, cycles, ok);
        repeat (2) cyc();
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL fall_not_latched got=%h ok=%0d exp=%h", got, ok, exp); end
        // clear lands in the same cycle the rise is seen: set wins
        sw_i[3] = 1'b1;
        wait_rd(2'd0, 32'h8, 32'h8, 40, cycles, ok);
        bus_write(2'd2, 32'h8);
        exp_q.push_back(32'h8);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL set_wins got=%h ok=%0d exp=%h", got, ok, exp); end
        bus_write(2'd2, 32'h8);
        exp_q.push_back(32'h0);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL w1c_sw3 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_mask();
        logic [31:0] got, exp;
        int cycles;
        bit ok1, ok2;
        bus_write(2'd3, 32'h0);
        sw_i[5] = 1'b0;
        wait_rd(2'd0, 32'h20, 32'h0, 40, cycles, ok1);
        sw_i[5] = 1'b1;
        wait_rd(2'd0, 32'h20, 32'h20, 40, cycles, ok2);
        repeat (2) cyc();
        exp_q.push_back(32'h20);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (!ok1 || !ok2 || got !== exp) begin bad++; $display("FAIL mask_edge5 got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL mask_irq_off got=%b exp=%h", bus.irq, exp); end
        bus_write(2'd3, 32'h20);
        exp_q.push_back(32'h20);
        bus_read(2'd3, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL mask_irq_en got=%h exp=%h", got, exp); end
        cyc();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL mask_irq_on got=%b exp=%h", bus.irq, exp); end
    endtask

    task automatic test_ro_and_sel();
        logic [31:0] got, exp;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h0);
        exp_q.push_back(32'hFFFF);
        bus_read(2'd0, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL ro_sw_state got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h1);
        bus_read(2'd1, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL ro_btn_state got=%h exp=%h", got, exp); end
        bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (bus.rdata !== exp) begin bad++; $display("FAIL nosel_rdata got=%h exp=%h", bus.rdata, exp); end
        bus.wr = 1'b1; bus.addr = 2'd2; bus.wdata = 32'hFFFF_FFFF;
        cyc();
        bus.addr = 2'd3; bus.wdata = 32'h0;
        cyc();
        bus.wr = 1'b0;
        exp_q.push_back(32'h20);
        bus_read(2'd2, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL nosel_edge got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h20);
        bus_read(2'd3, got);
        exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL nosel_irq_en got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if ({31'h0, bus.irq} !== exp) begin bad++; $display("FAIL nosel_irq got=%b exp=%h", bus.irq, exp); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_glitch();
        test_press();
        test_w1c();
        test_mask();
        test_ro_and_sel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
